qnr_div_sched: RTL and testbench

Issue scheduler and result buffer for the quantizer's shared pipelined divider. It arbitrates two quantizer requesters onto one fixed-latency, non-stallable divider pipeline. It tracks every in-flight operation with a tag shift register aligned to the divider stages and captures quotients into an output FIFO. Issue is credit-gated so a downstream stall can never drop a result. It sits between the quantizer lanes and the divider instance inside the quantizer.

---
 rtl/qnr_div_sched.sv | 181 ++++++++++++++++++
 tb/tb_qnr_div_sched.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/qnr_div_sched.sv
// rtl/qnr_div_sched.sv - credit-gated issue scheduler and result FIFO for the quantizer's shared divider
// Optional QNR_DIV_SCHED_STATS_EN adds stat_issued / stat_stall counters.
module qnr_div_sched #(
    parameter int NUM_W     = 16,
    parameter int DEN_W     = 8,
    parameter int Q_W       = 16,
    parameter int DIV_LAT   = 4,
    parameter int OUT_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [NUM_W-1:0] req0_num,
    input  logic [DEN_W-1:0] req0_den,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [NUM_W-1:0] req1_num,
    input  logic [DEN_W-1:0] req1_den,
    output logic             div_start,
    output logic [NUM_W-1:0] div_num,
    output logic [DEN_W-1:0] div_den,
    input  logic [Q_W-1:0]   div_q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Q_W-1:0]   out_q,
    output logic             out_id
`ifdef QNR_DIV_SCHED_STATS_EN
    ,
    output logic [31:0]      stat_issued,
    output logic [31:0]      stat_stall
`endif
);

    localparam int CW = $clog2(OUT_DEPTH + 1);

    logic [CW-1:0]      inflight_q, inflight_d;
    logic [CW-1:0]      fifo_count_q, fifo_count_d;
    logic               ptr_q, ptr_d;
    logic [DIV_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [DIV_LAT-1:0] tag_id_q, tag_id_d;
    logic [Q_W-1:0]     ent_q_q [OUT_DEPTH];
    logic [Q_W-1:0]     ent_q_d [OUT_DEPTH];
    logic [OUT_DEPTH-1:0] ent_id_q, ent_id_d;

    logic [CW:0]   used;
    logic          credit_ok;
    logic          grant0, grant1, grant, grant_id;
    logic          push, push_id, pop;
    logic [CW-1:0] wr_idx;

    // Every issued op owns one FIFO slot from grant until it is popped.
    always_comb begin
        used      = {1'b0, inflight_q} + {1'b0, fifo_count_q};
        credit_ok = (used < (CW+1)'(OUT_DEPTH)) && !rst;
        grant0    = 1'b0;
        grant1    = 1'b0;
        if (credit_ok) begin
            if (req0_valid && req1_valid) begin
                grant0 = !ptr_q;
                grant1 = ptr_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
        grant    = grant0 | grant1;
        grant_id = grant1;
    end

    always_comb begin
        req0_ready = grant0;
        req1_ready = grant1;
        div_start  = grant;
        div_num    = '0;
        div_den    = '0;
        if (grant1) begin
            div_num = req1_num;
            div_den = req1_den;
        end else if (grant0) begin
            div_num = req0_num;
            div_den = req0_den;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant) begin
            ptr_d = ~grant_id;
        end
        tag_vld_d    = tag_vld_q;
        tag_id_d     = tag_id_q;
        tag_vld_d[0] = grant;
        tag_id_d[0]  = grant_id;
        for (int i = 1; i < DIV_LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end
    end

    // Shift-register FIFO: entry 0 is the head, so out_q/out_id come straight from flops.
    always_comb begin
        push         = tag_vld_q[DIV_LAT-1];
        push_id      = tag_id_q[DIV_LAT-1];
        pop          = (fifo_count_q != '0) && out_ready;
        inflight_d   = inflight_q + CW'(grant) - CW'(push);
        fifo_count_d = fifo_count_q + CW'(push) - CW'(pop);
        wr_idx       = fifo_count_q - CW'(pop);
        ent_id_d     = ent_id_q;
        for (int i = 0; i < OUT_DEPTH; i++) begin
            ent_q_d[i] = ent_q_q[i];
        end
        for (int i = 0; i < OUT_DEPTH - 1; i++) begin
            if (pop) begin
                ent_q_d[i]  = ent_q_q[i+1];
                ent_id_d[i] = ent_id_q[i+1];
            end
        end
        for (int i = 0; i < OUT_DEPTH; i++) begin
            if (push && (wr_idx == CW'(i))) begin
                ent_q_d[i]  = div_q;
                ent_id_d[i] = push_id;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q   <= '0;
            fifo_count_q <= '0;
            ptr_q        <= 1'b0;
            tag_vld_q    <= '0;
            tag_id_q     <= '0;
            ent_id_q     <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                ent_q_q[i] <= '0;
            end
        end else begin
            inflight_q   <= inflight_d;
            fifo_count_q <= fifo_count_d;
            ptr_q        <= ptr_d;
            tag_vld_q    <= tag_vld_d;
            tag_id_q     <= tag_id_d;
            ent_id_q     <= ent_id_d;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                ent_q_q[i] <= ent_q_d[i];
            end
        end
    end

    assign out_valid = (fifo_count_q != '0);
    assign out_q     = ent_q_q[0];
    assign out_id    = ent_id_q[0];

`ifdef QNR_DIV_SCHED_STATS_EN
    logic [31:0] stat_issued_q, stat_issued_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    always_comb begin
        stat_issued_d = stat_issued_q + 32'(grant);
        stat_stall_d  = stat_stall_q;
        if ((req0_valid || req1_valid) && (used >= (CW+1)'(OUT_DEPTH))) begin
            stat_stall_d = stat_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            stat_issued_q <= stat_issued_d;
            stat_stall_q  <= stat_stall_d;
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_qnr_div_sched.sv
// tb/tb_qnr_div_sched.sv - directed self-checking bench for qnr_div_sched
// Two instances share requester inputs: depth 4 (credit corners) and depth 8 (round-robin).
module tb_qnr_div_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r0v, r1v, out_ready;
    logic [15:0] r0n, r1n;
    logic [7:0]  r0d, r1d;

    logic        a_r0rdy, a_r1rdy, a_start, a_ov, a_oid;
    logic [15:0] a_num, a_dq, a_oq;
    logic [7:0]  a_den;
    logic        b_r0rdy, b_r1rdy, b_start, b_ov, b_oid;
    logic [15:0] b_num, b_dq, b_oq;
    logic [7:0]  b_den;
`ifdef QNR_DIV_SCHED_STATS_EN
    logic [31:0] a_si, a_ss, b_si, b_ss;
`endif

    always #5 clk = ~clk;

    qnr_div_sched #(.DIV_LAT(4), .OUT_DEPTH(4)) u4 (
        .clk(clk), .rst(rst),
        .req0_valid(r0v), .req0_ready(a_r0rdy), .req0_num(r0n), .req0_den(r0d),
        .req1_valid(r1v), .req1_ready(a_r1rdy), .req1_num(r1n), .req1_den(r1d),
        .div_start(a_start), .div_num(a_num), .div_den(a_den), .div_q(a_dq),
`ifdef QNR_DIV_SCHED_STATS_EN
        .stat_issued(a_si), .stat_stall(a_ss),
`endif
        .out_valid(a_ov), .out_ready(out_ready), .out_q(a_oq), .out_id(a_oid)
    );

    qnr_div_sched #(.DIV_LAT(4), .OUT_DEPTH(8)) u8 (
        .clk(clk), .rst(rst),
        .req0_valid(r0v), .req0_ready(b_r0rdy), .req0_num(r0n), .req0_den(r0d),
        .req1_valid(r1v), .req1_ready(b_r1rdy), .req1_num(r1n), .req1_den(r1d),
        .div_start(b_start), .div_num(b_num), .div_den(b_den), .div_q(b_dq),
`ifdef QNR_DIV_SCHED_STATS_EN
        .stat_issued(b_si), .stat_stall(b_ss),
`endif
        .out_valid(b_ov), .out_ready(out_ready), .out_q(b_oq), .out_id(b_oid)
    );

    function automatic logic [15:0] quot(input logic [15:0] n, input logic [7:0] d);
        return (d == 8'd0) ? 16'hFFFF : n / {8'd0, d};
    endfunction

    // Four-cycle divider models
    logic [15:0] a_pipe [4];
    logic [15:0] b_pipe [4];
    always_ff @(posedge clk) begin
        a_pipe[0] <= quot(a_num, a_den);
        b_pipe[0] <= quot(b_num, b_den);
        for (int i = 1; i < 4; i++) begin
            a_pipe[i] <= a_pipe[i-1];
            b_pipe[i] <= b_pipe[i-1];
        end
    end
    assign a_dq = a_pipe[3];
    assign b_dq = b_pipe[3];

    int pass_cnt = 0;
    int total    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    bit          mon_en = 1'b0;
    logic [16:0] mon_q [$];
    always @(negedge clk) begin
        if (mon_en && b_ov && out_ready) mon_q.push_back({b_oid, b_oq});
    end

    typedef struct {
        logic        id;
        logic [15:0] num;
        logic [7:0]  den;
        logic [15:0] exp_q;
    } vec_t;

    vec_t vt [6];
    int   n;
    int   gcount;
    logic [2:0] exp_ids;

    initial begin
        vt[0] = '{1'b0, 16'd100,   8'd7,   16'd14};
        vt[1] = '{1'b1, 16'd1000,  8'd3,   16'd333};
        vt[2] = '{1'b0, 16'd65535, 8'd1,   16'd65535};
        vt[3] = '{1'b1, 16'd255,   8'd255, 16'd1};
        vt[4] = '{1'b0, 16'd7,     8'd0,   16'hFFFF};
        vt[5] = '{1'b1, 16'd0,     8'd5,   16'd0};

        rst = 1'b1; r0v = 1'b1; r1v = 1'b1; out_ready = 1'b0;
        r0n = 16'd0; r0d = 8'd1; r1n = 16'd0; r1d = 8'd1;
        tick(); tick(); #1;
        chk("rst_req0_ready", a_r0rdy, 0);
        chk("rst_req1_ready", a_r1rdy, 0);
        chk("rst_div_start", a_start, 0);
        chk("rst_out_valid", a_ov, 0);
        chk("rst_out_q", a_oq, 0);
        chk("rst_out_id", a_oid, 0);
        tick(); rst = 1'b0; r0v = 1'b0; r1v = 1'b0;

        for (int k = 0; k < 6; k++) begin
            tick();
            if (vt[k].id) begin r1v = 1'b1; r1n = vt[k].num; r1d = vt[k].den; end
            else          begin r0v = 1'b1; r0n = vt[k].num; r0d = vt[k].den; end
            #1;
            chk("op_grant", vt[k].id ? a_r1rdy : a_r0rdy, 1);
            chk("op_div_num", a_num, vt[k].num);
            chk("op_div_den", a_den, vt[k].den);
            tick(); r0v = 1'b0; r1v = 1'b0; n = 1; #1;
            while (!a_ov && n < 12) begin tick(); n++; #1; end
            chk("op_latency", n, 5);
            chk("op_out_q", a_oq, vt[k].exp_q);
            chk("op_out_id", a_oid, vt[k].id);
            out_ready = 1'b1;
            tick(); out_ready = 1'b0; #1;
            chk("op_popped_empty", a_ov, 0);
        end

        tick(); rst = 1'b1;
        tick(); rst = 1'b0; out_ready = 1'b1;
        r0n = 16'd200; r0d = 8'd10; r1n = 16'd30; r1d = 8'd3;
        mon_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(); r0v = 1'b1; r1v = 1'b1; #1;
            chk("rr_req0_ready", b_r0rdy, (i % 2 == 0) ? 1 : 0);
            chk("rr_req1_ready", b_r1rdy, (i % 2 == 1) ? 1 : 0);
        end
        tick(); r0v = 1'b0; r1v = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        mon_en = 1'b0;
        chk("rr_result_count", mon_q.size(), 8);
        for (int k = 0; k < 8 && k < mon_q.size(); k++) begin
            chk("rr_out_id", mon_q[k][16], k % 2);
            chk("rr_out_q", mon_q[k][15:0], (k % 2 == 0) ? 20 : 10);
        end

        tick(); rst = 1'b1; out_ready = 1'b0;
        tick(); rst = 1'b0;
        r0n = 16'd50; r0d = 8'd5; r1n = 16'd81; r1d = 8'd3;
        gcount = 0;
        for (int c = 0; c < 10; c++) begin
            tick(); r0v = 1'b1; r1v = 1'b1; #1;
            chk("stall_grant", a_r0rdy | a_r1rdy, (c < 4) ? 1 : 0);
            gcount += int'(a_r0rdy) + int'(a_r1rdy);
        end
        chk("stall_total_grants", gcount, 4);
        tick(); out_ready = 1'b1; #1;
`ifdef QNR_DIV_SCHED_STATS_EN
        chk("stat_issued", a_si, 4);
        chk("stat_stall", a_ss, 6);
`endif
        chk("stall_pop_cycle_no_grant", a_r0rdy | a_r1rdy, 0);
        chk("stall_head_id", a_oid, 0);
        chk("stall_head_q", a_oq, 10);
        tick(); out_ready = 1'b0; #1;
        chk("refill_req0_ready", a_r0rdy, 1);
        chk("refill_req1_ready", a_r1rdy, 0);
        chk("refill_head_id", a_oid, 1);
        chk("refill_head_q", a_oq, 27);
        tick(); r0v = 1'b0; r1v = 1'b0;
        tick(); tick();
        tick(); out_ready = 1'b1; #1;
        chk("pp_count_before", u4.fifo_count_q, 3);
        chk("pp_head_before", a_oid, 1);
        tick(); #1;
        chk("pp_count_after", u4.fifo_count_q, 3);
        exp_ids = 3'b010;
        for (int j = 0; j < 3; j++) begin
            chk("pp_valid", a_ov, 1);
            chk("pp_order_id", a_oid, exp_ids[j]);
            chk("pp_order_q", a_oq, exp_ids[j] ? 27 : 10);
            tick(); #1;
        end
        chk("pp_drained", a_ov, 0);
        out_ready = 1'b0;

        for (int i = 0; i < 3; i++) begin
            tick(); r0v = 1'b1; r1v = 1'b0; #1;
            chk("mf_grant", a_r0rdy, 1);
        end
        tick(); r0v = 1'b0; #1;
        chk("mf_inflight_before", u4.inflight_q, 3);
        rst = 1'b1;
        tick(); rst = 1'b0; #1;
        chk("mf_inflight_after", u4.inflight_q, 0);
        for (int i = 0; i < 8; i++) begin
            chk("mf_out_valid", a_ov, 0);
            tick(); #1;
        end
        r0v = 1'b1; r1v = 1'b1; #1;
        chk("mf_first_grant_req0", a_r0rdy, 1);
        chk("mf_first_grant_req1", a_r1rdy, 0);
        tick(); r0v = 1'b0; r1v = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
